// File: rtl/packet_tx_scheduler.sv
// ---------------------------------------------------------------------------
// packet_tx_scheduler
//
// Queues frame descriptors (start/end addresses into the packet buffer) and
// hands them one at a time to packet_synth. Each frame is started with a
// one-cycle synth_start pulse. The scheduler then waits for synth_done, or
// gives up after a watchdog expires. It then holds an inter-frame gap
// before the next launch.
//
// Ports
//   clk              system clock, all logic on its rising edge
//   reset            synchronous active-high reset
//   desc_valid       enqueue request for one descriptor
//   desc_start       first byte address of the frame
//   desc_end         end address of the frame (exclusive, may wrap)
//   desc_ready       queue has room for a descriptor
//   desc_drop        one-cycle pulse: offered descriptor was rejected
//   synth_start      one-cycle start pulse to packet_synth
//   synth_start_addr start address for packet_synth, held until next launch
//   synth_end_addr   end address for packet_synth, held until next launch
//   synth_done       end-of-frame pulse from packet_synth
//   timeout          one-cycle pulse when synth_done never arrived
//   busy             scheduler is not idle
//   queue_count      number of descriptors currently queued
// ---------------------------------------------------------------------------
module packet_tx_scheduler #(
    parameter int PACKET_BUFFER_SIZE = 2048,
    parameter int RAM_SIZE           = PACKET_BUFFER_SIZE,
    parameter int QUEUE_DEPTH        = 4,
    parameter int IFG_CYCLES         = 48,
    parameter int TIMEOUT_CYCLES     = 4096,
    localparam int W                 = $clog2(RAM_SIZE),
    localparam int CW                = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          desc_valid,
    input  logic [W-1:0]  desc_start,
    input  logic [W-1:0]  desc_end,
    output logic          desc_ready,
    output logic          desc_drop,
    output logic          synth_start,
    output logic [W-1:0]  synth_start_addr,
    output logic [W-1:0]  synth_end_addr,
    input  logic          synth_done,
    output logic          timeout,
    output logic          busy,
    output logic [CW-1:0] queue_count
);

    localparam int PW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW  = $clog2(IFG_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t         state_q;
    logic [W-1:0]   start_mem [QUEUE_DEPTH];
    logic [W-1:0]   end_mem   [QUEUE_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [WDW-1:0] wd_q;
    logic [GW-1:0]  gap_q;
    logic           synth_start_q, timeout_q, drop_q;
    logic [W-1:0]   start_addr_q, end_addr_q;
    logic           push, pop;

    // Ready comes straight from the registered count, so a full queue rejects
    // an offer even in a cycle where the head is being popped.
    assign desc_ready = (count_q < CW'(QUEUE_DEPTH));
    // Zero-length frames are never queued.
    assign push       = desc_valid && desc_ready && (desc_start != desc_end);
    assign pop        = (state_q == S_IDLE) && (count_q != '0);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        // A push and a pop in the same cycle cancel out.
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: descriptor storage is deliberately left without reset; a flush
    // only clears the pointers and count, and stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            start_mem[wr_ptr_q] <= desc_start;
            end_mem[wr_ptr_q]   <= desc_end;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wd_q          <= '0;
            gap_q         <= '0;
            synth_start_q <= 1'b0;
            timeout_q     <= 1'b0;
            drop_q        <= 1'b0;
            start_addr_q  <= '0;
            end_addr_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            drop_q        <= desc_valid && !push;
            synth_start_q <= 1'b0;
            timeout_q     <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        start_addr_q  <= start_mem[rd_ptr_q];
                        end_addr_q    <= end_mem[rd_ptr_q];
                        // Pulse lands in the LAUNCH cycle.
                        synth_start_q <= 1'b1;
                        state_q       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wd_q    <= WDW'(TIMEOUT_CYCLES - 1);
                    state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (synth_done) begin
                        gap_q   <= GW'(IFG_CYCLES - 1);
                        state_q <= S_GAP;
                    end else if (wd_q == '0) begin
                        timeout_q <= 1'b1;
                        gap_q     <= GW'(IFG_CYCLES - 1);
                        state_q   <= S_GAP;
                    end else begin
                        wd_q <= wd_q - WDW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
            endcase
        end
    end

    assign desc_drop        = drop_q;
    assign synth_start      = synth_start_q;
    assign timeout          = timeout_q;
    assign synth_start_addr = start_addr_q;
    assign synth_end_addr   = end_addr_q;
    assign busy             = (state_q != S_IDLE);
    assign queue_count      = count_q;

endmodule

// File: tb/tb_packet_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_packet_tx_scheduler
//
// Self-checking bench for packet_tx_scheduler (default parameters).
// The reference model tracks the queue as a SV queue. It tracks each frame
// by its launch cycle and the cycle at which the scheduler becomes idle
// again. Every output is predicted from those times each cycle. Directed
// scenarios cover latency, gap, full queue, zero-length drop, timeout and
// reset flush. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_packet_tx_scheduler;

    localparam int W     = 11;
    localparam int DEPTH = 4;
    localparam int IFG   = 48;
    localparam int TO    = 4096;

    logic         clk = 1'b0;
    logic         reset;
    logic         desc_valid;
    logic [W-1:0] desc_start, desc_end;
    logic         desc_ready, desc_drop;
    logic         synth_start;
    logic [W-1:0] synth_start_addr, synth_end_addr;
    logic         synth_done;
    logic         timeout, busy;
    logic [2:0]   queue_count;

    packet_tx_scheduler dut (
        .clk              (clk),
        .reset            (reset),
        .desc_valid       (desc_valid),
        .desc_start       (desc_start),
        .desc_end         (desc_end),
        .desc_ready       (desc_ready),
        .desc_drop        (desc_drop),
        .synth_start      (synth_start),
        .synth_start_addr (synth_start_addr),
        .synth_end_addr   (synth_end_addr),
        .synth_done       (synth_done),
        .timeout          (timeout),
        .busy             (busy),
        .queue_count      (queue_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] s;
        logic [W-1:0] e;
    } desc_t;

    desc_t        mq[$];
    bit           m_frame   = 0;  // a frame has been launched since reset
    int           m_l       = 0;  // cycle in which synth_start is high
    int           m_idle_at = -1; // first idle cycle after the frame, -1 = unknown
    logic [W-1:0] m_sa      = '0;
    logic [W-1:0] m_ea      = '0;

    // Evaluate the model for the current cycle's inputs, advance one clock,
    // then compare every DUT output with the prediction for the new cycle.
    task automatic tick();
        int    c;
        bit    ready, idle, e_busy, e_start, e_timeout, e_drop;
        desc_t d;
        c         = cyc;
        e_start   = 0;
        e_timeout = 0;
        e_drop    = 0;
        if (reset) begin
            mq.delete();
            m_frame   = 0;
            m_idle_at = -1;
            m_sa      = '0;
            m_ea      = '0;
        end else begin
            ready = (mq.size() < DEPTH);
            idle  = !m_frame || (m_idle_at >= 0 && c >= m_idle_at);
            // Waiting window for synth_done is cycles L+1 .. L+TO.
            if (m_frame && m_idle_at < 0 && c > m_l) begin
                if (synth_done) begin
                    m_idle_at = c + IFG + 1;
                end else if (c == m_l + TO) begin
                    e_timeout = 1;
                    m_idle_at = c + 1 + IFG;
                end
            end
            if (idle && mq.size() > 0) begin
                d         = mq.pop_front();
                m_sa      = d.s;
                m_ea      = d.e;
                m_frame   = 1;
                m_l       = c + 1;
                m_idle_at = -1;
                e_start   = 1;
            end
            if (desc_valid) begin
                if (ready && desc_start != desc_end) mq.push_back({desc_start, desc_end});
                else e_drop = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        e_busy = m_frame && !(m_idle_at >= 0 && cyc >= m_idle_at);
        check("synth_start", synth_start, e_start);
        check("timeout", timeout, e_timeout);
        check("desc_drop", desc_drop, e_drop);
        check("busy", busy, e_busy);
        check("desc_ready", desc_ready, mq.size() < DEPTH);
        check("queue_count", queue_count, mq.size());
        check("start_addr", synth_start_addr, m_sa);
        check("end_addr", synth_end_addr, m_ea);
    endtask

    task automatic enq(input int s, input int e);
        desc_valid = 1'b1;
        desc_start = W'(s);
        desc_end   = W'(e);
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // which: 0 = synth_start, 1 = timeout, 2 = not busy. Returns the cycle.
    task automatic wait_for(input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if ((which == 0 && synth_start) || (which == 1 && timeout) ||
                (which == 2 && !busy)) begin
                at = cyc;
                return;
            end
            tick();
        end
        check("wait_expired", 0, 1);
    endtask

    initial begin
        int n0, l1, d, at, t, n;

        reset      = 1'b1;
        desc_valid = 1'b0;
        desc_start = '0;
        desc_end   = '0;
        synth_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", desc_ready, 1);
        check("rst_qcount", queue_count, 0);
        check("rst_busy", busy, 0);
        check("rst_start", synth_start, 0);

        // Launch latency from an idle, empty scheduler.
        n0 = cyc;
        enq(0, 73);
        wait_for(0, 10, at);
        check("s1_latency", at, n0 + 2);
        check("s1_start_addr", synth_start_addr, 0);
        check("s1_end_addr", synth_end_addr, 73);
        check("s1_busy", busy, 1);

        // Back-to-back frames separated by the inter-frame gap.
        do_reset();
        enq(0, 73);
        enq(100, 180);
        wait_for(0, 10, l1);
        while (cyc < l1 + 300) tick();
        synth_done = 1'b1;
        d = cyc;
        tick();
        synth_done = 1'b0;
        wait_for(0, 100, at);
        check("s2_restart", at, d + 50);
        check("s2_start_addr", synth_start_addr, 100);
        check("s2_end_addr", synth_end_addr, 180);

        // Fill the queue while a frame is in flight.
        tick();
        for (int i = 0; i < 5; i++) begin
            desc_valid = 1'b1;
            desc_start = W'(10 * i + 1);
            desc_end   = W'(10 * i + 5);
            if (i == 4) check("s3_ready_full", desc_ready, 0);
            tick();
        end
        desc_valid = 1'b0;
        check("s3_drop", desc_drop, 1);
        check("s3_qcount", queue_count, 4);

        // Zero-length descriptor is dropped.
        do_reset();
        enq(20, 20);
        check("s4_drop", desc_drop, 1);
        check("s4_qcount", queue_count, 0);
        n = 0;
        repeat (10) begin
            tick();
            if (synth_start) n++;
        end
        check("s4_no_start", n, 0);

        // Watchdog expiry, with a wrapping descriptor.
        enq(1500, 200);
        wait_for(0, 10, l1);
        check("s5_start_addr", synth_start_addr, 1500);
        check("s5_end_addr", synth_end_addr, 200);
        wait_for(1, TO + 10, t);
        check("s5_timeout_at", t, l1 + TO + 1);
        wait_for(2, IFG + 10, at);
        check("s5_idle_at", at, t + IFG);

        // Reset in the gap flushes the queue.
        enq(1, 2);
        wait_for(0, 10, l1);
        tick();
        synth_done = 1'b1;
        tick();
        synth_done = 1'b0;
        enq(3, 4);
        enq(5, 6);
        repeat (5) tick();
        check("s6_qcount_before", queue_count, 2);
        check("s6_busy_before", busy, 1);
        do_reset();
        check("s6_qcount_after", queue_count, 0);
        check("s6_busy_after", busy, 0);
        n = 0;
        repeat (100) begin
            tick();
            if (synth_start) n++;
        end
        check("s6_no_start", n, 0);

        // Randomized traffic.
        repeat (15000) begin
            reset      = ($urandom_range(2999) == 0);
            desc_valid = ($urandom_range(19) == 0);
            desc_start = W'($urandom);
            desc_end   = ($urandom_range(7) == 0) ? desc_start : W'($urandom);
            synth_done = ($urandom_range(119) == 0);
            tick();
        end
        reset      = 1'b0;
        desc_valid = 1'b0;
        synth_done = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/packet_tx_scheduler.md
PACKET_TX_SCHEDULER -- requirements
Module: packet_tx_scheduler

Interface
REQ-001 Parameter RAM_SIZE, default PACKET_BUFFER_SIZE, packet buffer depth in bytes; W = clog2(RAM_SIZE).
REQ-002 Parameter QUEUE_DEPTH, default 4, descriptor FIFO entries (power of two).
REQ-003 Parameter IFG_CYCLES, default 48, inter-frame gap in clk cycles (96 bit times at 2 bits/cycle, 50 MHz).
REQ-004 Parameter TIMEOUT_CYCLES, default 4096, max cycles waiting for synth_done.
REQ-005 Port clk  in  1  single system clock (50 MHz); all logic on posedge clk.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port desc_valid  in  1  enqueue request for one frame descriptor.
REQ-008 Port desc_start  in  W  first byte address of frame in packet buffer.
REQ-009 Port desc_end  in  W  end address of frame, exclusive, passed unchanged to packet_synth.
REQ-010 Port desc_ready  out  1  high when queue can accept a descriptor.
REQ-011 Port desc_drop  out  1  one-cycle pulse: descriptor offered and rejected.
REQ-012 Port synth_start  out  1  one-cycle start pulse to packet_synth.
REQ-013 Port synth_start_addr  out  W  data_ram_start_in for packet_synth; stable from synth_start until next launch.
REQ-014 Port synth_end_addr  out  W  data_ram_end_in for packet_synth; same stability.
REQ-015 Port synth_done  in  1  one-cycle pulse from packet_synth at end of frame (after FCS).
REQ-016 Port timeout  out  1  one-cycle pulse when WAIT_DONE expires.
REQ-017 Port busy  out  1  high in any state other than IDLE.
REQ-018 Port queue_count  out  clog2(QUEUE_DEPTH+1)  entries currently queued.

Function
REQ-019 Descriptor accepted in a cycle when desc_valid && desc_ready && desc_start != desc_end; written to FIFO at that clock edge.
REQ-020 desc_ready = (queue_count < QUEUE_DEPTH), combinational from registered count.
REQ-021 desc_valid with desc_start == desc_end, or with desc_ready low, drops descriptor; desc_drop high in the following cycle.
REQ-022 desc_end < desc_start (ring wrap) is legal and accepted unchanged.
REQ-023 FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
REQ-024 IDLE: if queue_count != 0, pop head, register addresses into synth_*_addr, go LAUNCH; else stay.
REQ-025 LAUNCH: synth_start = 1 for exactly this cycle; load watchdog with TIMEOUT_CYCLES-1; go WAIT_DONE.
REQ-026 WAIT_DONE: on synth_done go GAP, load gap counter with IFG_CYCLES-1; else if watchdog == 0 pulse timeout next cycle and go GAP; else decrement watchdog.
REQ-027 GAP: decrement gap counter; at 0 go IDLE.
REQ-028 synth_done outside WAIT_DONE is ignored.
REQ-029 Latency: descriptor accepted in cycle N with scheduler idle and queue empty -> synth_start high in cycle N+2.
REQ-030 synth_done in cycle D with non-empty queue -> next synth_start in cycle D+IFG_CYCLES+2.
REQ-031 Simultaneous enqueue and pop in one cycle: both take effect; queue_count unchanged.
REQ-032 FIFO read/write pointers wrap modulo QUEUE_DEPTH; order strictly FIFO.
REQ-033 synth_start, timeout and desc_drop are registered outputs, never high two cycles in a row.

Reset
REQ-034 reset sampled high: next edge state = IDLE, queue flushed (pointers and queue_count = 0), counters = 0.
REQ-035 Output values during/after reset: synth_start = 0, timeout = 0, desc_drop = 0, busy = 0, synth_start_addr = 0, synth_end_addr = 0, desc_ready = 1.
REQ-036 Reset mid-frame (WAIT_DONE or GAP) abandons frame and discards all queued descriptors; no further synth_start until a new descriptor.

Verification
REQ-037 Reset release, enqueue (0,73) in cycle N -> synth_start in cycle N+2 with addrs 0/73; busy high from N+2.
REQ-038 Enqueue (0,73),(100,180); synth_done pulsed 300 cycles after first start in cycle D -> second synth_start in cycle D+50 with addrs 100/180.
REQ-039 Scheduler in WAIT_DONE (head popped), enqueue 5 descriptors back-to-back -> first 4 accepted, 5th: desc_ready low, desc_drop pulse, queue_count = 4.
REQ-040 Enqueue (20,20) -> desc_drop pulse, queue_count stays 0, no synth_start.
REQ-041 Launch, never assert synth_done -> timeout pulse TIMEOUT_CYCLES+1 cycles after synth_start, then IDLE after IFG_CYCLES more.
REQ-042 Reset asserted during GAP with 2 queued -> queue_count 0, busy 0, no synth_start for 100 cycles after release.
